instr_fetch_unit: RTL

- Per-column instruction supply stage sitting directly upstream of data_path.
- Holds the column's instruction memory, filled by the host loader.
- Owns the 12-bit program counter and executes the clken_PC / load_PC / incr_PC / load_value_PC controls that data_path emits.
- Returns the 32-bit instruction on instr; num_col instances are placed side by side, and their instr and control buses concatenate column-major.

---
 rtl/cgra_fetch_pkg.sv | 12 +
 rtl/imem_sdp_ram.sv | 29 ++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cgra_fetch_pkg.sv
// Shared constants and types for the per-column instruction fetch stage.
package cgra_fetch_pkg;

  localparam int unsigned dwidth_inst = 32;
  localparam int unsigned pc_width    = 12;
  localparam int unsigned imem_depth  = 2 ** pc_width;

  typedef enum logic {LOAD, RUN} fetch_state_t;

  typedef logic [pc_width-1:0] pc_t;

endpackage

// File: rtl/imem_sdp_ram.sv
// Simple dual-port instruction memory: one write port, one registered read port.
// A write to the address being read returns the new data (write-first).
module imem_sdp_ram #(
  parameter int unsigned width      = 32,
  parameter int unsigned addr_width = 12,
  parameter int unsigned depth      = 4096
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [width-1:0]      wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [width-1:0]      rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Per-column instruction fetch: host loader fills imem, then the PC walks it under data_path control.
// Optional IMEM_BOUND_CHECK_EN adds fetch_err and zeroes fetches beyond the highest loaded address.
module instr_fetch_unit
  import cgra_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_wen,
  input  logic [pc_width-1:0]    ld_waddr,
  input  logic [dwidth_inst-1:0] ld_wdata,
  input  logic                   ld_last,
  input  logic                   reload,
  input  logic                   clken_PC,
  input  logic                   load_PC,
  input  logic                   incr_PC,
  input  logic [pc_width-1:0]    load_value_PC,
  output logic [dwidth_inst-1:0] instr,
  output logic [pc_width-1:0]    pc,
  output logic                   done_loader
`ifdef IMEM_BOUND_CHECK_EN
  ,
  output logic                   fetch_err
`endif
);

  fetch_state_t           state_q, state_d;
  pc_t                    pc_q, pc_d;
  logic                   ram_we;
  logic [dwidth_inst-1:0] ram_rdata;
  logic                   run;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ram_we  = 1'b0;
    unique case (state_q)
      LOAD: begin
        pc_d   = '0;
        ram_we = ld_wen;
        if (ld_wen && ld_last) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (reload) begin
          state_d = LOAD;
          pc_d    = '0;
        end else if (clken_PC) begin
          if (load_PC) begin
            pc_d = load_value_PC;
          end else if (incr_PC) begin
            pc_d = pc_q + pc_t'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Reading at pc_d keeps the registered RAM output aligned with pc_q.
  imem_sdp_ram #(
    .width      (dwidth_inst),
    .addr_width (pc_width),
    .depth      (imem_depth)
  ) u_imem (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ld_waddr),
    .wdata (ld_wdata),
    .raddr (pc_d),
    .rdata (ram_rdata)
  );

  // Gating by state gives the async-reset zero on instr without resetting the RAM.
  assign run         = (state_q == RUN);
  assign pc          = pc_q;
  assign done_loader = run;

`ifdef IMEM_BOUND_CHECK_EN
  pc_t  max_q;
  logic err_q;
  logic oob;

  assign oob = run && (pc_q > max_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q <= '0;
      err_q <= 1'b0;
    end else if (run && reload) begin
      max_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (ram_we && (ld_waddr > max_q)) begin
        max_q <= ld_waddr;
      end
      if (oob) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_err = err_q | oob;
  assign instr     = (run && !oob) ? ram_rdata : '0;
`else
  assign instr     = run ? ram_rdata : '0;
`endif

endmodule
